// File: rtl/fproc_arbiter_if.sv
// rtl/fproc_arbiter_if.sv - per-core and shared-fproc signal bundle for fproc_arbiter
//
// Purpose: groups the per-core request/return signals and the shared fproc
//   request/result signals that pass through the arbiter.
// Signals:
//   core_enable  per-core one-cycle request pulse
//   core_id      per-core request id, FPROC_ID_WIDTH bits per core
//   core_ready   per-core one-cycle result-valid pulse
//   core_data    per-core result, DATA_WIDTH bits per core
//   fp_enable    one-cycle request to the shared fproc
//   fp_id        id of the granted request
//   fp_core_sel  index of the granted core
//   fp_ready     shared fproc result valid
//   fp_data      shared fproc result
// Modports: slave = arbiter side, master = cores plus shared fproc side.
interface fproc_arbiter_if #(
  parameter int N_CORES        = 4,
  parameter int FPROC_ID_WIDTH = 8,
  parameter int DATA_WIDTH     = 32
);
  localparam int SEL_W = $clog2(N_CORES);

  logic [N_CORES-1:0]                core_enable;
  logic [N_CORES*FPROC_ID_WIDTH-1:0] core_id;
  logic [N_CORES-1:0]                core_ready;
  logic [N_CORES*DATA_WIDTH-1:0]     core_data;
  logic                              fp_enable;
  logic [FPROC_ID_WIDTH-1:0]         fp_id;
  logic [SEL_W-1:0]                  fp_core_sel;
  logic                              fp_ready;
  logic [DATA_WIDTH-1:0]             fp_data;

  modport slave (
    input  core_enable, core_id, fp_ready, fp_data,
    output core_ready, core_data, fp_enable, fp_id, fp_core_sel
  );

  modport master (
    output core_enable, core_id, fp_ready, fp_data,
    input  core_ready, core_data, fp_enable, fp_id, fp_core_sel
  );
endinterface

// File: rtl/fproc_arbiter.sv
// rtl/fproc_arbiter.sv - round-robin arbiter sharing one fproc among N_CORES cores
//
// Purpose: latches one-cycle fproc requests from each core, grants them
//   round-robin, issues one request at a time to the shared fproc, waits for
//   its result and returns it to the requesting core only.
// Ports:
//   clk          clock
//   reset        synchronous active-high reset
//   bus          fproc_arbiter_if.slave (per-core and shared-fproc signals)
//   busy         high whenever the FSM is not IDLE
//   dup_err      sticky: request from a core that already had one pending
//   timeout_err  sticky WAIT timeout flag
// Optional feature: define FPROC_ARB_TIMEOUT_EN to bound the WAIT state to
//   TIMEOUT_CYCLES cycles; without it timeout_err is tied low.
module fproc_arbiter #(
  parameter int N_CORES        = 4,
  parameter int FPROC_ID_WIDTH = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic           clk,
  input  logic           reset,
  fproc_arbiter_if.slave bus,
  output logic           busy,
  output logic           dup_err,
  output logic           timeout_err
);
  localparam int SEL_W = $clog2(N_CORES);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RETURN} state_t;

  state_t                    state, state_n;
  logic [N_CORES-1:0]        pending;
  logic [FPROC_ID_WIDTH-1:0] id_reg [N_CORES];
  logic [DATA_WIDTH-1:0]     data_reg [N_CORES];
  logic [SEL_W-1:0]          last_grant;
  logic [SEL_W-1:0]          sel_q;
  logic [FPROC_ID_WIDTH-1:0] id_q;

  logic                      grant_valid;
  logic [SEL_W-1:0]          grant_idx;
  logic                      grant_take;
  logic [N_CORES-1:0]        grant_clr;
  logic [N_CORES-1:0]        pend_kept;
  logic                      ret_load;
  logic [DATA_WIDTH-1:0]     ret_data;
  logic                      wait_expired;

  // Round-robin search over the registered pending set, starting one past
  // the last grant and wrapping.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= N_CORES; k++) begin
      if (!grant_valid && pending[(int'(last_grant) + k) % N_CORES]) begin
        grant_valid = 1'b1;
        grant_idx   = SEL_W'((int'(last_grant) + k) % N_CORES);
      end
    end
  end

  always_comb begin
    state_n    = state;
    grant_take = 1'b0;
    ret_load   = 1'b0;
    ret_data   = bus.fp_data;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          grant_take = 1'b1;
          state_n    = ISSUE;
        end
      end
      // fp_ready is deliberately not looked at here: the resource never
      // answers in the same cycle it is asked.
      ISSUE: state_n = WAIT;
      WAIT: begin
        if (bus.fp_ready) begin
          ret_load = 1'b1;
          state_n  = RETURN;
        end else if (wait_expired) begin
          ret_load = 1'b1;
          ret_data = '1;
          state_n  = RETURN;
        end
      end
      RETURN:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // A grant frees its slot before capture, so a request landing in the grant
  // cycle becomes a fresh pending request rather than a duplicate.
  assign grant_clr = grant_take ? (N_CORES'(1) << grant_idx) : '0;
  assign pend_kept = pending & ~grant_clr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pending    <= '0;
      last_grant <= SEL_W'(N_CORES - 1);
      sel_q      <= '0;
      id_q       <= '0;
      dup_err    <= 1'b0;
      for (int i = 0; i < N_CORES; i++) begin
        id_reg[i]   <= '0;
        data_reg[i] <= '0;
      end
    end else begin
      state   <= state_n;
      pending <= pend_kept | bus.core_enable;
      if (|(bus.core_enable & pend_kept)) dup_err <= 1'b1;
      for (int i = 0; i < N_CORES; i++) begin
        if (bus.core_enable[i] && !pend_kept[i])
          id_reg[i] <= bus.core_id[i*FPROC_ID_WIDTH +: FPROC_ID_WIDTH];
      end
      if (grant_take) begin
        sel_q      <= grant_idx;
        last_grant <= grant_idx;
        id_q       <= id_reg[grant_idx];
      end
      // Loaded on the way into RETURN so the slice is valid alongside core_ready.
      if (ret_load) data_reg[sel_q] <= ret_data;
    end
  end

`ifdef FPROC_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == ISSUE) wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + CNT_W'(1);
      // A result arriving on the limit cycle wins over the timeout.
      if (wait_expired && !bus.fp_ready) timeout_q <= 1'b1;
    end
  end

  // Expires on the WAIT cycle whose increment would bring the count to the limit.
  assign wait_expired = (state == WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err  = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign wait_expired       = 1'b0;
  assign timeout_err        = 1'b0;
`endif

  assign busy            = (state != IDLE);
  assign bus.fp_enable   = (state == ISSUE);
  assign bus.fp_id       = id_q;
  assign bus.fp_core_sel = sel_q;
  assign bus.core_ready  = (state == RETURN) ? (N_CORES'(1) << sel_q) : '0;

  for (genvar g = 0; g < N_CORES; g++) begin : g_core_data
    assign bus.core_data[g*DATA_WIDTH +: DATA_WIDTH] = data_reg[g];
  end
endmodule

// File: tb/tb_fproc_arbiter.sv
// tb/tb_fproc_arbiter.sv - scoreboard testbench for fproc_arbiter
module tb_fproc_arbiter;
  localparam int N  = 4;
  localparam int IW = 8;
  localparam int DW = 32;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] id;
    int         cyc;
  } fp_exp_t;

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] data;
    int          cyc;
  } core_exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy, dup_err, timeout_err;

  fproc_arbiter_if #(.N_CORES(N), .FPROC_ID_WIDTH(IW), .DATA_WIDTH(DW)) bus ();

  fproc_arbiter #(
    .N_CORES(N), .FPROC_ID_WIDTH(IW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .busy(busy), .dup_err(dup_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rdy_cyc = -100;
  int          resp_delay = 3;
  logic        resp_hold = 1'b0;
  logic        resp_glitch = 1'b0;
  logic        r_ready = 1'b0;
  logic [31:0] r_data = '0;
  logic        m_ready = 1'b0;
  logic [31:0] mdl [N];
  fp_exp_t     fp_q [$];
  core_exp_t   core_q [$];
  fp_exp_t     fe;
  core_exp_t   ce;
  int          g;

  assign bus.fp_ready = r_ready | m_ready;
  assign bus.fp_data  = m_ready ? 32'h0BAD0BAD : r_data;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rdata_of(input logic [7:0] id);
    return (id == 8'h05) ? 32'hDEADBEEF : {8'hD0, id, 8'h00, id};
  endfunction

  task automatic exp_fp(input logic [1:0] sel, input logic [7:0] id, input int c);
    fp_exp_t e;
    e.sel = sel; e.id = id; e.cyc = c;
    fp_q.push_back(e);
  endtask

  task automatic exp_core(input logic [3:0] mask, input logic [31:0] data, input int c);
    core_exp_t e;
    e.mask = mask; e.data = data; e.cyc = c;
    core_q.push_back(e);
  endtask

  // Shared-fproc model: answers each fp_enable after resp_delay cycles.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (bus.fp_enable && !resp_hold && !reset) begin
        if (resp_glitch) begin
          r_ready = 1'b1;
          r_data  = 32'hFFFF0000;
        end
        repeat (resp_delay) begin
          @(posedge clk); #1;
          r_ready = 1'b0;
        end
        r_ready = 1'b1;
        r_data  = rdata_of(bus.fp_id);
        rdy_cyc = cyc;
        @(posedge clk); #1;
        r_ready = 1'b0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents fp_enable or core_ready.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.fp_enable) begin
        if (fp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_fp_enable: actual core %0d id %0h required none", bus.fp_core_sel, bus.fp_id);
        end else begin
          fe = fp_q.pop_front();
          chk("fp_core_sel", bus.fp_core_sel, fe.sel);
          chk("fp_id", bus.fp_id, fe.id);
          if (fe.cyc >= 0) chk("fp_enable_cycle", cyc, fe.cyc);
        end
      end
      if (|bus.core_ready) begin
        if (core_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_core_ready: actual %0h required none", bus.core_ready);
        end else begin
          ce = core_q.pop_front();
          chk("core_ready", bus.core_ready, ce.mask);
          g = 0;
          for (int i = 0; i < N; i++) if (ce.mask[i]) g = i;
          mdl[g] = ce.data;
          chk("core_data_slice", bus.core_data[g*DW +: DW], ce.data);
          chk("core_data_all", bus.core_data, {mdl[3], mdl[2], mdl[1], mdl[0]});
          chk("core_ready_cycle", cyc, (ce.cyc >= 0) ? ce.cyc : rdy_cyc + 1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse(input logic [3:0] mask, input logic [31:0] ids);
    bus.core_enable = mask;
    bus.core_id     = ids;
    tick();
    bus.core_enable = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < N; i++) mdl[i] = '0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((fp_q.size() != 0 || core_q.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL drain_timeout: actual %0d fp / %0d core outstanding required 0", fp_q.size(), core_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual no finish required finish");
    $fatal(1);
  end

  initial begin
    bus.core_enable = '0;
    bus.core_id     = '0;
    for (int i = 0; i < N; i++) mdl[i] = '0;
    reset = 1'b1;
    repeat (3) tick();

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_dup_err", dup_err, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_fp_enable", bus.fp_enable, 0);
    chk("rst_core_ready", bus.core_ready, 0);
    chk("rst_core_data", bus.core_data, 0);
    chk("rst_fp_id", bus.fp_id, 0);
    chk("rst_fp_core_sel", bus.fp_core_sel, 0);
    reset = 1'b0;
    tick();

    // Single request, latency checked
    exp_fp(2'd1, 8'h05, cyc + 2);
    exp_core(4'b0010, 32'hDEADBEEF, -1);
    pulse(4'b0010, 32'h0000_0500);
    wait_drain(60);

    // Simultaneous requests from reset priority
    do_reset();
    exp_fp(2'd0, 8'h10, -1);
    exp_fp(2'd1, 8'h11, -1);
    exp_fp(2'd2, 8'h12, -1);
    exp_fp(2'd3, 8'h13, -1);
    exp_core(4'b0001, 32'hD0100010, -1);
    exp_core(4'b0010, 32'hD0110011, -1);
    exp_core(4'b0100, 32'hD0120012, -1);
    exp_core(4'b1000, 32'hD0130013, -1);
    pulse(4'b1111, 32'h1312_1110);
    wait_drain(100);

    // Round-robin fairness with immediate re-requests
    for (int r = 0; r < 3; r++) begin
      exp_fp(2'd0, 8'h20, -1);
      exp_fp(2'd2, 8'h22, -1);
      exp_core(4'b0001, 32'hD0200020, -1);
      exp_core(4'b0100, 32'hD0220022, -1);
    end
    pulse(4'b0101, 32'h0022_0020);
    for (int r = 0; r < 4; r++) begin
      int n;
      n = 0;
      while (!(|bus.core_ready) && n < 100) begin
        tick();
        n++;
      end
      checks++;
      if (n >= 100) begin
        errors++;
        $display("FAIL rr_wait_timeout: actual no core_ready required core_ready");
      end
      pulse(bus.core_ready, 32'h0022_0020);
    end
    wait_drain(100);

    // Duplicate request from core 3 while pending
    chk("dup_err_before", dup_err, 0);
    exp_fp(2'd1, 8'h41, -1);
    exp_fp(2'd3, 8'h33, -1);
    exp_core(4'b0010, 32'hD0410041, -1);
    exp_core(4'b1000, 32'hD0330033, -1);
    pulse(4'b0010, 32'h0000_4100);
    pulse(4'b1000, 32'h3300_0000);
    pulse(4'b1000, 32'h3F00_0000);
    chk("dup_err_set", dup_err, 1);
    wait_drain(100);
    chk("dup_err_sticky", dup_err, 1);

    // fp_ready during ISSUE is ignored
    resp_glitch = 1'b1;
    exp_fp(2'd2, 8'h52, -1);
    exp_core(4'b0100, 32'hD0520052, -1);
    pulse(4'b0100, 32'h0052_0000);
    wait_drain(60);
    resp_glitch = 1'b0;
    chk("dup_err_sticky2", dup_err, 1);

    // Reset while waiting, with core 1 pending
    resp_hold = 1'b1;
    exp_fp(2'd0, 8'h60, -1);
    pulse(4'b0001, 32'h0000_0060);
    pulse(4'b0010, 32'h0000_6100);
    tick(); tick(); tick();
    chk("wait_busy", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < N; i++) mdl[i] = '0;
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("post_reset_busy", busy, 0);
      tick();
    end
    chk("post_reset_dup_err", dup_err, 0);
    chk("post_reset_core_data", bus.core_data, 0);
    chk("post_reset_fp_core_sel", bus.fp_core_sel, 0);
    chk("post_reset_fp_q", fp_q.size(), 0);
    resp_hold = 1'b0;

`ifdef FPROC_ARB_TIMEOUT_EN
    // WAIT timeout returns all ones and sets the sticky flag
    chk("timeout_err_before", timeout_err, 0);
    resp_hold = 1'b1;
    exp_fp(2'd0, 8'h70, cyc + 2);
    exp_core(4'b0001, 32'hFFFFFFFF, cyc + 11);
    pulse(4'b0001, 32'h0000_0070);
    wait_drain(60);
    chk("timeout_err_set", timeout_err, 1);
    resp_hold = 1'b0;
`endif

    tick(); tick();
    chk("end_fp_q_empty", fp_q.size(), 0);
    chk("end_core_q_empty", core_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fproc_arbiter.md
Name: fproc_arbiter

Overview:
- Shares one function-processor (fproc) resource among N_CORES distributed processor cores.
- Each core issues one-cycle fproc requests (enable + id). The block latches them, grants round-robin, drives the single fproc request port, waits for the result, and routes ready/data back to the requesting core only.
- Sits between the per-core fproc interfaces and the shared fproc/measurement-result block in the multi-core toplevel.

Parameters:
- N_CORES, 4, number of requesting cores (≥2)
- FPROC_ID_WIDTH, 8, width of the fproc id field
- DATA_WIDTH, 32, width of the fproc result
- TIMEOUT_CYCLES, 1024, WAIT-state limit (used only with the optional feature)

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high reset
- core_enable  in  N_CORES  per-core one-cycle request pulse
- core_id  in  N_CORES*FPROC_ID_WIDTH  per-core id; slice i = [FPROC_ID_WIDTH*(i+1)-1 : FPROC_ID_WIDTH*i]
- core_ready  out  N_CORES  one-cycle result-valid pulse to the granted core
- core_data  out  N_CORES*DATA_WIDTH  per-core result, sliced the same way as core_id
- fp_enable  out  1  one-cycle request to the shared fproc
- fp_id  out  FPROC_ID_WIDTH  id of the granted request
- fp_core_sel  out  $clog2(N_CORES)  index of the granted core
- fp_ready  in  1  shared fproc result valid
- fp_data  in  DATA_WIDTH  shared fproc result
- busy  out  1  high whenever the state is not IDLE
- dup_err  out  1  sticky: request received from a core that already had one pending
- timeout_err  out  1  sticky timeout flag (optional feature)

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - State = IDLE; pending[] = 0; captured ids = 0.
  - last_grant = N_CORES-1, so core 0 has highest priority first.
  - All outputs = 0. Reset mid-transaction aborts it: no core_ready is issued and fp_ready is ignored after reset.
- Request capture (every cycle, every state):
  - If core_enable[i]=1 and pending[i]=0: set pending[i] and store id_reg[i] = core_id slice i.
  - If pending[i] is already 1: drop the request, keep the stored id, set dup_err.
  - A request arriving in the same cycle that pending[i] is cleared by a grant is captured as a new pending request.
- Arbitration:
  - Round-robin; search starts at (last_grant+1) mod N_CORES and wraps.
  - Combinational over registered pending[], so a request pulsed at cycle t can be granted in IDLE at t+1.
- FSM:
  - IDLE: if any pending, latch grant index g into fp_core_sel, fp_id = id_reg[g], clear pending[g], last_grant = g, go to ISSUE.
  - ISSUE: fp_enable = 1 for exactly this cycle; go to WAIT. fp_ready is ignored here; the resource guarantees ≥1 cycle latency.
  - WAIT: on fp_ready=1, register data_reg = fp_data and go to RETURN; otherwise stay.
  - RETURN: core_ready[g] = 1 for one cycle and core_data slice g = data_reg; go to IDLE.
- Latency: request pulse at cycle t → fp_enable at t+2 with an idle arbiter. fp_ready at cycle r → core_ready at r+1.
- Output holding:
  - core_data slice i holds its last returned value until the next return to core i; other slices are unaffected.
  - fp_id and fp_core_sel hold from ISSUE until the next grant.
- Throughput: at most one transaction in flight. Back-to-back grants are possible: RETURN → IDLE → ISSUE, so there is a minimum 4-cycle gap between fp_enable pulses.

Optional Feature:
- Macro: FPROC_ARB_TIMEOUT_EN
- Defined:
  - A counter (width $clog2(TIMEOUT_CYCLES+1)) clears on WAIT entry and increments each WAIT cycle.
  - When the count reaches TIMEOUT_CYCLES without fp_ready, go to RETURN with data_reg = all ones and set sticky timeout_err.
  - fp_ready in the same cycle as the limit takes priority: real data is returned and no flag is set.
- Not defined: WAIT has no limit, no counter is built, and timeout_err is tied to 0.

Test Plan:
- Single request: reset, then core 1 pulses enable with id=0x05 at t0; fp_ready with data 0xDEADBEEF three cycles after fp_enable → fp_enable at t0+2 with fp_id=0x05 and fp_core_sel=1; core_ready=4'b0010 one cycle after fp_ready; core_data slice 1 = 0xDEADBEEF; other slices = 0.
- Simultaneous requests: all 4 cores pulse in the same cycle with ids 0x10–0x13 → grants in order 0,1,2,3 with matching fp_id values; each core_ready is returned only to its own core.
- Round-robin fairness: cores 0 and 2 re-request immediately after each core_ready → grants alternate 0,2,0,2; core 0 is never granted twice in a row while core 2 is pending.
- Boundaries:
  - Duplicate pulse from core 3 while pending → single transaction, dup_err = 1 and stays 1.
  - fp_ready asserted during ISSUE → ignored; the FSM waits for the next fp_ready.
- Reset in WAIT: reset while waiting, then fp_ready pulses → no core_ready; busy = 0; all pending cleared.
- With FPROC_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: grant with no fp_ready → core_ready after 8 WAIT cycles with data 0xFFFFFFFF and timeout_err = 1.
